// File: rtl/micro_pkg.sv
// micro_pkg: shared types and the default microcode table for micro_sequencer.
//   seq_state_t : sequencer states (FETCH, EXEC, HALT)
//   op_kind_t   : per-opcode behaviour class (NORMAL, BRANCH_Z, HALT, ILLEGAL)
//   uop_entry_t : one table row {uop, last, kind}
//   table_entry : (opcode, z, step) -> uop_entry_t
//   max_table_len : longest sequence in the table, used for the width check
package micro_pkg;

    localparam int TBL_UOP_W = 6;
    localparam int TBL_OPC_N = 64;

    localparam int OPC_JZ   = 52;
    localparam int OPC_NOP  = 56;
    localparam int OPC_HALT = 57;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        OPK_NORMAL,
        OPK_BRANCH_Z,
        OPK_HALT,
        OPK_ILLEGAL
    } op_kind_t;

    typedef struct packed {
        logic [TBL_UOP_W-1:0] uop;
        logic                 last;
        op_kind_t             kind;
    } uop_entry_t;

    function automatic op_kind_t seq_kind(input int opc);
        if (opc == OPC_JZ)
            return OPK_BRANCH_Z;
        if (opc == OPC_HALT)
            return OPK_HALT;
        if (opc inside {4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33,
                        [36:51], 55, 56, 58, 59})
            return OPK_NORMAL;
        return OPK_ILLEGAL;
    endfunction

    function automatic int seq_len(input int opc, input logic z);
        if (opc inside {4, 8})                      return 4;
        if (opc inside {12, 14, 16})                return 2;
        if (opc inside {18, 21, 24, 27, 30, 33})    return 3;
        if (opc == OPC_JZ)                          return z ? 2 : 4;
        return 1;
    endfunction

    function automatic uop_entry_t table_entry(input int opc, input logic z, input int step);
        uop_entry_t e;
        int         val;
        e.kind = seq_kind(opc);
        e.last = (step >= seq_len(opc, z) - 1);
        case (e.kind)
            OPK_BRANCH_Z: begin
                // Taken branch (z=1) is the short 54,56 path.
                if (z)
                    val = (step == 0) ? 54 : OPC_NOP;
                else begin
                    case (step)
                        0:       val = 52;
                        2:       val = 53;
                        default: val = OPC_NOP;
                    endcase
                end
            end
            OPK_HALT:    val = OPC_HALT;
            OPK_ILLEGAL: val = OPC_NOP;
            default:     val = opc + step;
        endcase
        e.uop = TBL_UOP_W'(val);
        return e;
    endfunction

    function automatic int max_table_len();
        int m;
        m = 0;
        for (int o = 0; o < TBL_OPC_N; o++) begin
            if (seq_len(o, 1'b0) > m) m = seq_len(o, 1'b0);
            if (seq_len(o, 1'b1) > m) m = seq_len(o, 1'b1);
        end
        return m;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational microcode lookup built from micro_pkg.
//   opcode : opcode to decode (OPC_W)
//   z      : zero flag selecting the branch path
//   step   : step index within the EXEC sequence (STEP_W)
//   entry  : {uop, last, kind} for that step
module microcode_rom
    import micro_pkg::*;
#(
    parameter int OPC_W  = 6,
    parameter int STEP_W = 2
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic              z,
    input  logic [STEP_W-1:0] step,
    output uop_entry_t        entry
);

    always_comb begin
        entry = table_entry(int'(opcode), z, int'(step));
    end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-step sequencer. Runs the fetch micro-sequence, then
// the per-opcode exec micro-sequence from microcode_rom, then returns to fetch.
//   clk, reset   : clock, synchronous active-high reset
//   start, stall : run enable / memory wait; the sequencer advances on start & ~stall
//   opcode, z_in : instruction and zero flag, sampled at exec step 0
//   uop          : registered micro-op code; uop_valid marks live steps
//   step         : step index of the current cycle within its sequence
//   fetch_phase  : 1 while in fetch; halted : 1 while in halt
//   illegal_op   : one-cycle pulse on an undecoded opcode
module micro_sequencer
    import micro_pkg::*;
#(
    parameter  int OPC_W      = 6,
    parameter  int UOP_W      = 6,
    parameter  int MAX_STEPS  = 4,
    parameter  int FETCH_LEN  = 3,
    parameter  int FETCH_BASE = 1,
    parameter  int NOP_UOP    = 56,
    parameter  int HALT_OPC   = 57,
    localparam int STEP_W     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              z_in,
    output logic [UOP_W-1:0]  uop,
    output logic              uop_valid,
    output logic [STEP_W-1:0] step,
    output logic              fetch_phase,
    output logic              halted,
    output logic              illegal_op
);

    localparam int TBL_MAX = max_table_len();

    if (TBL_MAX > MAX_STEPS || FETCH_LEN > MAX_STEPS || FETCH_LEN < 1) begin : g_cfg_err
        $error("micro_sequencer: sequence length exceeds MAX_STEPS");
    end

    seq_state_t        state;
    logic [STEP_W-1:0] step_cnt;
    logic [OPC_W-1:0]  opc_q;
    logic              z_q;
    logic [OPC_W-1:0]  rom_opc;
    logic              rom_z;
    logic              advance;
    uop_entry_t        entry;

    assign advance = start & ~stall;

    // Step 0 decodes the live inputs; later steps use the latched copies so
    // opcode/z_in changes mid-sequence cannot alter the running sequence.
    assign rom_opc = (step_cnt == '0) ? opcode : opc_q;
    assign rom_z   = (step_cnt == '0) ? z_in   : z_q;

    microcode_rom #(
        .OPC_W  (OPC_W),
        .STEP_W (STEP_W)
    ) u_rom (
        .opcode (rom_opc),
        .z      (rom_z),
        .step   (step_cnt),
        .entry  (entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            step_cnt    <= '0;
            step        <= '0;
            uop         <= UOP_W'(NOP_UOP);
            uop_valid   <= 1'b0;
            fetch_phase <= 1'b1;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            opc_q       <= '0;
            z_q         <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                ST_HALT: begin
                    // uop and step hold; only reset leaves this state.
                    uop_valid   <= 1'b0;
                    halted      <= 1'b1;
                    fetch_phase <= 1'b0;
                end
                ST_FETCH: begin
                    fetch_phase <= 1'b1;
                    halted      <= 1'b0;
                    step        <= step_cnt;
                    if (advance) begin
                        uop       <= UOP_W'(FETCH_BASE) + UOP_W'(step_cnt);
                        uop_valid <= 1'b1;
                        if (step_cnt == STEP_W'(FETCH_LEN - 1)) begin
                            step_cnt <= '0;
                            state    <= ST_EXEC;
                        end else begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                    end else begin
                        uop       <= UOP_W'(NOP_UOP);
                        uop_valid <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    fetch_phase <= 1'b0;
                    halted      <= 1'b0;
                    step        <= step_cnt;
                    if (advance) begin
                        uop_valid <= 1'b1;
                        if (step_cnt == '0) begin
                            opc_q <= opcode;
                            z_q   <= z_in;
                        end
                        case (entry.kind)
                            OPK_ILLEGAL: begin
                                uop        <= UOP_W'(NOP_UOP);
                                illegal_op <= 1'b1;
                                step_cnt   <= '0;
                                state      <= ST_FETCH;
                            end
                            OPK_HALT: begin
                                uop      <= UOP_W'(HALT_OPC);
                                step_cnt <= '0;
                                state    <= ST_HALT;
                            end
                            default: begin
                                uop <= UOP_W'(entry.uop);
                                if (entry.last) begin
                                    step_cnt <= '0;
                                    state    <= ST_FETCH;
                                end else begin
                                    step_cnt <= step_cnt + STEP_W'(1);
                                end
                            end
                        endcase
                    end else begin
                        uop       <= UOP_W'(NOP_UOP);
                        uop_valid <= 1'b0;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: scoreboard bench for micro_sequencer. The stimulus
// process drives inputs, advances a list-based reference model and queues the
// expected outputs; a monitor pops and compares after each clock edge.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stall, z_in;
    logic [5:0] opcode;
    logic [5:0] uop;
    logic       uop_valid;
    logic [1:0] step;
    logic       fetch_phase, halted, illegal_op;

    micro_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .opcode      (opcode),
        .z_in        (z_in),
        .uop         (uop),
        .uop_valid   (uop_valid),
        .step        (step),
        .fetch_phase (fetch_phase),
        .halted      (halted),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] uop;
        logic       valid;
        logic [1:0] step;
        logic       fetch;
        logic       halted;
        logic       illegal;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0=fetch, 1=exec, 2=halt. The running exec
    // sequence is held as a list of micro-ops chosen when exec begins.
    int m_mode = 0;
    int m_pos  = 0;
    int m_seq[$];
    int m_kind = 0;   // 0 normal, 1 halt, 2 illegal
    int m_last_uop  = 56;
    int m_last_step = 0;

    task automatic ref_seq(input int opc, input bit z);
        m_seq.delete();
        m_kind = 0;
        if (opc == 4 || opc == 8) begin
            for (int i = 0; i < 4; i++) m_seq.push_back(opc + i);
        end else if (opc inside {12, 14, 16}) begin
            m_seq.push_back(opc); m_seq.push_back(opc + 1);
        end else if (opc inside {18, 21, 24, 27, 30, 33}) begin
            for (int i = 0; i < 3; i++) m_seq.push_back(opc + i);
        end else if (opc inside {[36:51], 55, 56, 58, 59}) begin
            m_seq.push_back(opc);
        end else if (opc == 52) begin
            if (z) m_seq = '{54, 56};
            else   m_seq = '{52, 56, 53, 56};
        end else if (opc == 57) begin
            m_kind = 1; m_seq.push_back(57);
        end else begin
            m_kind = 2; m_seq.push_back(56);
        end
    endtask

    task automatic model(input bit rst, input bit st, input bit sl,
                         input int opc, input bit z, output obs_t e);
        e = '0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_seq.delete();
            e.uop = 6'd56; e.fetch = 1'b1;
        end else if (m_mode == 2) begin
            e.uop = 6'(m_last_uop); e.step = 2'(m_last_step); e.halted = 1'b1;
        end else if (!(st && !sl)) begin
            e.uop = 6'd56; e.step = 2'(m_pos); e.fetch = (m_mode == 0);
        end else if (m_mode == 0) begin
            e.uop = 6'(1 + m_pos); e.valid = 1'b1; e.step = 2'(m_pos); e.fetch = 1'b1;
            m_pos++;
            if (m_pos == 3) begin m_mode = 1; m_pos = 0; end
        end else begin
            if (m_pos == 0) ref_seq(opc, z);
            e.valid = 1'b1;
            e.step  = 2'(m_pos);
            e.uop   = 6'(m_seq[m_pos]);
            if (m_kind == 2) begin
                e.illegal = 1'b1; m_mode = 0; m_pos = 0;
            end else if (m_kind == 1) begin
                m_mode = 2; m_pos = 0;
            end else begin
                m_pos++;
                if (m_pos == m_seq.size()) begin m_mode = 0; m_pos = 0; end
            end
        end
        m_last_uop  = int'(e.uop);
        m_last_step = int'(e.step);
    endtask

    task automatic drive(input bit rst, input bit st, input bit sl, input int opc, input bit z);
        obs_t e;
        reset  = rst;
        start  = st;
        stall  = sl;
        opcode = 6'(opc);
        z_in   = z;
        model(rst, st, sl, opc, z, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit st, input bit sl, input int opc, input bit z);
        for (int i = 0; i < n; i++) drive(1'b0, st, sl, opc, z);
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        obs_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{uop: uop, valid: uop_valid, step: step, fetch: fetch_phase,
                        halted: halted, illegal: illegal_op};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got uop=%0d v=%0b step=%0d f=%0b h=%0b ill=%0b required uop=%0d v=%0b step=%0d f=%0b h=%0b ill=%0b",
                             $time, got.uop, got.valid, got.step, got.fetch, got.halted, got.illegal,
                             e.uop, e.valid, e.step, e.fetch, e.halted, e.illegal);
                end
            end
        end
    end

    initial begin
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        // Fetch then opcode 4 (four steps), fetch then opcode 40 (one step).
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(4, 1'b1, 1'b0, 4, 1'b0);
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(1, 1'b1, 1'b0, 40, 1'b0);
        // JZ not taken, then taken.
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(4, 1'b1, 1'b0, 52, 1'b0);
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(2, 1'b1, 1'b0, 52, 1'b1);
        // JZ with opcode and z_in changed after step 0.
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(1, 1'b1, 1'b0, 52, 1'b0);
        run(3, 1'b1, 1'b0, 4, 1'b1);
        // Illegal opcode, then fetch resumes.
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(1, 1'b1, 1'b0, 60, 1'b0);
        run(1, 1'b1, 1'b0, 0, 1'b0);
        // Opcode 8 with a stall at step 2.
        run(2, 1'b1, 1'b0, 0, 1'b0);
        run(2, 1'b1, 1'b0, 8, 1'b0);
        run(3, 1'b1, 1'b1, 8, 1'b0);
        run(2, 1'b1, 1'b0, 8, 1'b0);
        // Reset in the middle of opcode 18.
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(2, 1'b1, 1'b0, 18, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 18, 1'b0);
        // Halt, with start and stall toggling, then reset.
        run(3, 1'b1, 1'b0, 0, 1'b0);
        run(1, 1'b1, 1'b0, 57, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) < 90),
                  1'($urandom_range(0, 99) < 20),
                  $urandom_range(0, 63),
                  1'($urandom_range(0, 1)));
        end
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
